// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port 16-bit memory between a read-only fetch port and a
// read/write data port. Accesses are serialised (IDLE -> ACCESS -> RESP); each
// access holds the memory signals for LATENCY cycles and then returns a
// one-cycle ack to the winner. Data normally wins, but fetch is forced through
// once it has lost STARVE_LIMIT consecutive arbitrations.
// Build option: define MEM_ARB_ALIGN_CHECK_EN to reject odd addresses with err
// (no memory access) instead of forwarding them to the memory unchanged.
// Legal ranges: LATENCY 1..7, STARVE_LIMIT 1..15.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int LATENCY      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [15:0]           i_rdata,
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [15:0]           d_wdata,
  output logic                  d_ack,
  output logic [15:0]           d_rdata,
  output logic                  err,
  output logic                  m_enable,
  output logic                  m_wr,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [15:0]           m_wdata,
  input  logic [15:0]           m_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [2:0] LAST_CNT   = 3'(LATENCY - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t                r_state,    w_state_nxt;
  logic [2:0]            r_cnt,      w_cnt_nxt;
  logic [3:0]            r_starve,   w_starve_nxt;
  logic                  r_wr,       w_wr_nxt;
  logic                  r_sel_d,    w_sel_d_nxt;
  logic                  r_i_ack,    w_i_ack_nxt;
  logic [15:0]           r_i_rdata,  w_i_rdata_nxt;
  logic                  r_d_ack,    w_d_ack_nxt;
  logic [15:0]           r_d_rdata,  w_d_rdata_nxt;
  logic                  r_err,      w_err_nxt;
  logic                  r_m_enable, w_m_enable_nxt;
  logic                  r_m_wr,     w_m_wr_nxt;
  logic [ADDR_WIDTH-1:0] r_m_addr,   w_m_addr_nxt;
  logic [15:0]           r_m_wdata,  w_m_wdata_nxt;
  logic                  r_busy,     w_busy_nxt;

  logic                  w_fetch_wins;
  logic [ADDR_WIDTH-1:0] w_win_addr;
  logic                  w_win_wr;

  assign i_ack    = r_i_ack;
  assign i_rdata  = r_i_rdata;
  assign d_ack    = r_d_ack;
  assign d_rdata  = r_d_rdata;
  assign err      = r_err;
  assign m_enable = r_m_enable;
  assign m_wr     = r_m_wr;
  assign m_addr   = r_m_addr;
  assign m_wdata  = r_m_wdata;
  assign busy     = r_busy;

  // Arbitration: data first, unless fetch has starved for STARVE_LIMIT rounds.
  always_comb begin
    w_fetch_wins = i_req && (!d_req || (r_starve == STARVE_MAX));
    if (w_fetch_wins) begin
      w_win_addr = i_addr;
      w_win_wr   = 1'b0;
    end else begin
      w_win_addr = d_addr;
      w_win_wr   = d_wr;
    end
  end

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_starve_nxt   = r_starve;
    w_wr_nxt       = r_wr;
    w_sel_d_nxt    = r_sel_d;
    w_i_ack_nxt    = 1'b0;
    w_i_rdata_nxt  = r_i_rdata;
    w_d_ack_nxt    = 1'b0;
    w_d_rdata_nxt  = r_d_rdata;
    w_err_nxt      = 1'b0;
    w_m_enable_nxt = 1'b0;
    w_m_wr_nxt     = 1'b0;
    w_m_addr_nxt   = r_m_addr;
    w_m_wdata_nxt  = r_m_wdata;
    w_busy_nxt     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_req || d_req) begin
          // Starvation only grows when fetch asked and lost; saturates at the limit.
          if (w_fetch_wins || !i_req) begin
            w_starve_nxt = 4'd0;
          end else if (r_starve != STARVE_MAX) begin
            w_starve_nxt = r_starve + 4'd1;
          end else begin
            w_starve_nxt = r_starve;
          end
          w_sel_d_nxt   = !w_fetch_wins;
          w_wr_nxt      = w_win_wr;
          w_m_addr_nxt  = w_win_addr;
          w_m_wdata_nxt = w_fetch_wins ? 16'd0 : d_wdata;
          w_cnt_nxt     = 3'd0;
          w_busy_nxt    = 1'b1;
`ifdef MEM_ARB_ALIGN_CHECK_EN
          if (w_win_addr[0]) begin
            // Misaligned: memory is left untouched; respond with err and zero data.
            w_state_nxt = ST_RESP;
            w_err_nxt   = 1'b1;
            if (w_fetch_wins) begin
              w_i_ack_nxt   = 1'b1;
              w_i_rdata_nxt = 16'd0;
            end else begin
              w_d_ack_nxt   = 1'b1;
              w_d_rdata_nxt = 16'd0;
            end
          end else begin
            w_state_nxt    = ST_ACCESS;
            w_m_enable_nxt = 1'b1;
            w_m_wr_nxt     = w_win_wr && (LAST_CNT == 3'd0);
          end
`else
          w_state_nxt    = ST_ACCESS;
          w_m_enable_nxt = 1'b1;
          // A single-cycle access writes in its first (and only) cycle.
          w_m_wr_nxt     = w_win_wr && (LAST_CNT == 3'd0);
`endif
        end else begin
          w_starve_nxt = 4'd0;
          w_state_nxt  = ST_IDLE;
        end
      end

      ST_ACCESS: begin
        w_busy_nxt = 1'b1;
        if (r_cnt == LAST_CNT) begin
          // Final edge of the access: capture read data, raise ack, release memory.
          w_state_nxt = ST_RESP;
          if (r_sel_d) begin
            w_d_ack_nxt   = 1'b1;
            w_d_rdata_nxt = r_wr ? 16'd0 : m_rdata;
          end else begin
            w_i_ack_nxt   = 1'b1;
            w_i_rdata_nxt = m_rdata;
          end
        end else begin
          w_cnt_nxt      = r_cnt + 3'd1;
          w_m_enable_nxt = 1'b1;
          // Strobe the write only in the last held cycle so each access writes once.
          w_m_wr_nxt     = r_wr && ((r_cnt + 3'd1) == LAST_CNT);
        end
      end

      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers; rst abandons any access in flight without an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 3'd0;
      r_starve   <= 4'd0;
      r_wr       <= 1'b0;
      r_sel_d    <= 1'b0;
      r_i_ack    <= 1'b0;
      r_i_rdata  <= 16'd0;
      r_d_ack    <= 1'b0;
      r_d_rdata  <= 16'd0;
      r_err      <= 1'b0;
      r_m_enable <= 1'b0;
      r_m_wr     <= 1'b0;
      r_m_addr   <= {ADDR_WIDTH{1'b0}};
      r_m_wdata  <= 16'd0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_starve   <= w_starve_nxt;
      r_wr       <= w_wr_nxt;
      r_sel_d    <= w_sel_d_nxt;
      r_i_ack    <= w_i_ack_nxt;
      r_i_rdata  <= w_i_rdata_nxt;
      r_d_ack    <= w_d_ack_nxt;
      r_d_rdata  <= w_d_rdata_nxt;
      r_err      <= w_err_nxt;
      r_m_enable <= w_m_enable_nxt;
      r_m_wr     <= w_m_wr_nxt;
      r_m_addr   <= w_m_addr_nxt;
      r_m_wdata  <= w_m_wdata_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a LATENCY=1 instance exercised with short
// directed sequences, and a LATENCY=3 instance driven by random requesters and
// compared every cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int LAT  = 3;
  localparam int SLIM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic init_mem;

  // LATENCY=3 instance
  logic        i_req, i_ack, d_req, d_wr, d_ack, err, m_enable, m_wr, busy;
  logic [15:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic [15:0] mem [0:255];

  // LATENCY=1 instance
  logic        i_req1, i_ack1, d_req1, d_wr1, d_ack1, err1, m_enable1, m_wr1, busy1;
  logic [15:0] i_addr1, i_rdata1, d_addr1, d_wdata1, d_rdata1, m_addr1, m_wdata1, m_rdata1;
  logic [15:0] mem1 [0:255];

  mem_port_arbiter #(.ADDR_WIDTH(16), .LATENCY(LAT), .STARVE_LIMIT(SLIM)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
    .m_enable(m_enable), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_WIDTH(16), .LATENCY(1), .STARVE_LIMIT(SLIM)) dut1 (
    .clk(clk), .rst(rst),
    .i_req(i_req1), .i_addr(i_addr1), .i_ack(i_ack1), .i_rdata(i_rdata1),
    .d_req(d_req1), .d_wr(d_wr1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_ack(d_ack1), .d_rdata(d_rdata1), .err(err1),
    .m_enable(m_enable1), .m_wr(m_wr1), .m_addr(m_addr1), .m_wdata(m_wdata1),
    .m_rdata(m_rdata1), .busy(busy1)
  );

  assign m_rdata  = mem[m_addr[7:0]];
  assign m_rdata1 = mem1[m_addr1[7:0]];

  // Memories: image loaded while init_mem is high, written on enable+write strobe.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int k = 0; k < 256; k++) begin
        mem[k]  <= 16'(k) ^ 16'hA5A5;
        mem1[k] <= 16'(k) ^ 16'hA5A5;
      end
    end else begin
      if (m_enable && m_wr)   mem[m_addr[7:0]]   <= m_wdata;
      if (m_enable1 && m_wr1) mem1[m_addr1[7:0]] <= m_wdata1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one transaction at a time, timing from plain arithmetic.
  logic [15:0] ref_mem [0:255];
  int          ev        = 0;
  int          g_edge    = -1000;
  int          next_free = 0;
  int          starve    = 0;
  int          pct       = 0;
  bit          hot       = 1'b0;
  bit          g_d, g_wr;
  logic [15:0] g_addr, g_wdata;
  logic [15:0] exp_i_rdata = 16'd0;
  logic [15:0] exp_d_rdata = 16'd0;

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    a = 16'($urandom_range(0, 47));
`ifdef MEM_ARB_ALIGN_CHECK_EN
    a[0] = 1'b0;
`endif
    return a;
  endfunction

  task automatic model_edge();
    bit          fw;
    logic [15:0] rd;
    ev++;
    if (rst) begin
      g_edge      = -1000;
      next_free   = ev + 1;
      starve      = 0;
      exp_i_rdata = 16'd0;
      exp_d_rdata = 16'd0;
    end else begin
      if (ev >= next_free) begin
        if (i_req || d_req) begin
          fw = i_req && (!d_req || starve == SLIM);
          if (fw || !i_req) starve = 0;
          else if (starve < SLIM) starve++;
          g_edge    = ev;
          next_free = ev + LAT + 2;
          g_d       = !fw;
          g_wr      = !fw && d_wr;
          g_addr    = fw ? i_addr : d_addr;
          g_wdata   = fw ? 16'd0 : d_wdata;
        end else begin
          starve = 0;
        end
      end
      if (ev == g_edge + LAT) begin
        if (g_wr) begin
          ref_mem[g_addr[7:0]] = g_wdata;
          rd = 16'd0;
        end else begin
          rd = ref_mem[g_addr[7:0]];
        end
        if (g_d) exp_d_rdata = rd;
        else     exp_i_rdata = rd;
      end
    end
  endtask

  // One clock of the LATENCY=3 instance: model, edge, compare, then requesters.
  task automatic step();
    bit en, mw, bz, ack;
    model_edge();
    @(posedge clk);
    #1;
    en  = (ev >= g_edge) && (ev <= g_edge + LAT - 1);
    mw  = en && g_wr && (ev == g_edge + LAT - 1);
    bz  = (ev >= g_edge) && (ev <= g_edge + LAT);
    ack = (ev == g_edge + LAT);
    check_eq("i_ack",    32'(i_ack),    32'(ack && !g_d));
    check_eq("d_ack",    32'(d_ack),    32'(ack && g_d));
    check_eq("i_rdata",  32'(i_rdata),  32'(exp_i_rdata));
    check_eq("d_rdata",  32'(d_rdata),  32'(exp_d_rdata));
    check_eq("m_enable", 32'(m_enable), 32'(en));
    check_eq("m_wr",     32'(m_wr),     32'(mw));
    check_eq("busy",     32'(busy),     32'(bz));
    check_eq("err",      32'(err),      32'(0));
    if (en) check_eq("m_addr",  32'(m_addr),  32'(g_addr));
    if (mw) check_eq("m_wdata", 32'(m_wdata), 32'(g_wdata));
    if (rst) begin
      check_eq("rst_m_addr",  32'(m_addr),  32'(0));
      check_eq("rst_m_wdata", 32'(m_wdata), 32'(0));
      i_req = 1'b0;
      d_req = 1'b0;
    end else begin
      if (ack && !g_d) i_req = 1'b0;
      if (ack && g_d)  d_req = 1'b0;
      if (!i_req && (hot || int'($urandom_range(0, 99)) < pct)) begin
        i_req  = 1'b1;
        i_addr = rand_addr();
      end
      if (!d_req && (hot || int'($urandom_range(0, 99)) < pct)) begin
        d_req   = 1'b1;
        d_wr    = 1'($urandom_range(0, 1));
        d_addr  = rand_addr();
        d_wdata = 16'($urandom);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] saved;
    int          diffs;
    rst = 1'b1; init_mem = 1'b1;
    i_req = 1'b0; i_addr = 16'd0; d_req = 1'b0; d_wr = 1'b0; d_addr = 16'd0; d_wdata = 16'd0;
    i_req1 = 1'b0; i_addr1 = 16'd0; d_req1 = 1'b0; d_wr1 = 1'b0; d_addr1 = 16'd0; d_wdata1 = 16'd0;
    for (int k = 0; k < 256; k++) ref_mem[k] = 16'(k) ^ 16'hA5A5;
    tick(); tick();
    init_mem = 1'b0;

    // LATENCY=1 instance: reset state
    check_eq("r1_d_ack",    32'(d_ack1),    32'(0));
    check_eq("r1_i_ack",    32'(i_ack1),    32'(0));
    check_eq("r1_m_enable", 32'(m_enable1), 32'(0));
    check_eq("r1_busy",     32'(busy1),     32'(0));
    check_eq("r1_d_rdata",  32'(d_rdata1),  32'(0));
    rst = 1'b0;

    // Write 0xBEEF to 0x0010, sampled at edge 0
    d_req1 = 1'b1; d_wr1 = 1'b1; d_addr1 = 16'h0010; d_wdata1 = 16'hBEEF;
    tick();  // cycle 1
    check_eq("w1_m_wr",     32'(m_wr1),     32'(1));
    check_eq("w1_m_enable", 32'(m_enable1), 32'(1));
    check_eq("w1_m_addr",   32'(m_addr1),   32'h0010);
    check_eq("w1_m_wdata",  32'(m_wdata1),  32'hBEEF);
    check_eq("w1_d_ack_c1", 32'(d_ack1),    32'(0));
    check_eq("w1_busy_c1",  32'(busy1),     32'(1));
    tick();  // cycle 2
    check_eq("w1_d_ack_c2", 32'(d_ack1),    32'(1));
    check_eq("w1_d_rdata",  32'(d_rdata1),  32'(0));
    check_eq("w1_m_wr_c2",  32'(m_wr1),     32'(0));
    check_eq("w1_m_en_c2",  32'(m_enable1), 32'(0));
    d_wr1 = 1'b0;  // next request: read back 0x0010
    tick();  // cycle 3 (IDLE)
    check_eq("r1_d_ack_c3", 32'(d_ack1),    32'(0));
    check_eq("r1_busy_c3",  32'(busy1),     32'(0));
    tick();  // cycle 4
    check_eq("r1_m_en_c4",  32'(m_enable1), 32'(1));
    check_eq("r1_m_wr_c4",  32'(m_wr1),     32'(0));
    tick();  // cycle 5
    check_eq("r1_d_ack_c5", 32'(d_ack1),    32'(1));
    check_eq("r1_d_rdata",  32'(d_rdata1),  32'hBEEF);
    check_eq("r1_i_ack_c5", 32'(i_ack1),    32'(0));
    d_req1 = 1'b0; i_req1 = 1'b1; i_addr1 = 16'h0003;
    tick();  // cycle 6 (IDLE)
    check_eq("f1_d_ack_c6", 32'(d_ack1),    32'(0));
    tick();  // cycle 7
`ifdef MEM_ARB_ALIGN_CHECK_EN
    check_eq("f1_i_ack",    32'(i_ack1),    32'(1));
    check_eq("f1_err",      32'(err1),      32'(1));
    check_eq("f1_i_rdata",  32'(i_rdata1),  32'(0));
    check_eq("f1_m_enable", 32'(m_enable1), 32'(0));
    i_req1 = 1'b0;
    tick();
    check_eq("f1_m_en_aft", 32'(m_enable1), 32'(0));
`else
    check_eq("f1_m_enable", 32'(m_enable1), 32'(1));
    check_eq("f1_m_addr",   32'(m_addr1),   32'h0003);
    check_eq("f1_err_c7",   32'(err1),      32'(0));
    tick();  // cycle 8
    check_eq("f1_i_ack",    32'(i_ack1),    32'(1));
    check_eq("f1_i_rdata",  32'(i_rdata1),  32'hA5A6);
    check_eq("f1_err_c8",   32'(err1),      32'(0));
    check_eq("f1_d_hold",   32'(d_rdata1),  32'hBEEF);
    i_req1 = 1'b0;
`endif

    // LATENCY=3 instance: reset state, then random traffic
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    pct = 40;
    repeat (400) step();

    // Both ports continuously requesting: starvation rotation
    hot = 1'b1;
    repeat (80) step();
    hot = 1'b0; pct = 0;
    repeat (14) step();

    // Directed write of 0x1234 to 0x0020
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
    repeat (6) step();
    check_eq("mem_0x20", 32'(mem[8'h20]), 32'h1234);

    // Write to 0x0022 abandoned by rst in its 2nd ACCESS cycle
    saved = ref_mem[8'h22];
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0022; d_wdata = 16'h5555;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (4) step();
    check_eq("abort_mem", 32'(mem[8'h22]), 32'(saved));

    pct = 40;
    repeat (300) step();
    pct = 0;
    repeat (14) step();

    diffs = 0;
    for (int k = 0; k < 256; k++) begin
      if (mem[k] !== ref_mem[k]) diffs++;
    end
    check_eq("mem_image", 32'(diffs), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
